// File: rtl/lc3b_pkg.sv
// Shared LC-3b datapath constants and the write-back payload type.
package lc3b_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned NUM_REGS   = 8;

  localparam int unsigned REQ_ALU  = 0;
  localparam int unsigned REQ_MEM  = 1;
  localparam int unsigned REQ_LINK = 2;
  localparam int unsigned NUM_REQ  = 3;

  localparam logic [REG_ADDR_W-1:0] R7 = 3'd7;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dr;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from the last winner + 1.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               accept_i,
  output logic [NUM_REQ-1:0] grant_o
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] gidx;
  logic             found;

  // Rotating priority search; the first valid requester after last wins.
  always_comb begin
    grant_o = '0;
    idx     = '0;
    gidx    = last_q;
    found   = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((32'(last_q) + k) % NUM_REQ);
      if (!found && req_i[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end
    if (found && !reset_i) grant_o[gidx] = 1'b1;
    last_d = accept_i ? gidx : last_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) last_q <= IDX_W'(NUM_REQ - 1);
    else         last_q <= last_d;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back port arbiter for the LC-3b register file with a per-register
// pending scoreboard for read-after-write hazard detection.
module regfile_wb_arbiter #(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned REG_ADDR_W = 3
) (
  input  logic                         clk_50,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_dr,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         rsv_valid,
  input  logic [REG_ADDR_W-1:0]        rsv_dr,
  output logic                         rsv_ready,
  input  logic [REG_ADDR_W-1:0]        sr1,
  input  logic [REG_ADDR_W-1:0]        sr2,
  output logic                         sr1_busy,
  output logic                         sr2_busy,
  output logic [DATA_W-1:0]            rf_in,
  output logic [REG_ADDR_W-1:0]        rf_dr,
  output logic                         rf_ldreg
);

  import lc3b_pkg::*;

  localparam int unsigned NREG = 1 << REG_ADDR_W;

  logic [NUM_REQ-1:0]    grant;
  logic                  accept;
  logic [REG_ADDR_W-1:0] dr_arr   [NUM_REQ];
  logic [DATA_W-1:0]     data_arr [NUM_REQ];
  wb_req_t               sel;
  wb_req_t               wb_q, wb_d;
  logic                  ldreg_q, ldreg_d;
  logic [NREG-1:0]       pending_q, pending_d;
  logic                  rsv_accept;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .clk_i    (clk_50),
    .reset_i  (reset),
    .req_i    (req_valid),
    .accept_i (accept),
    .grant_o  (grant)
  );

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign dr_arr[g]   = req_dr[g*REG_ADDR_W +: REG_ADDR_W];
    assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
  end

  // Grant is one-hot, so the mux reduces to an OR of the selected lanes.
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel.dr   = dr_arr[i];
        sel.data = data_arr[i];
      end
    end
  end

  always_comb begin
    ldreg_d = accept;
    wb_d    = accept ? sel : wb_q;
  end

  // A register may be re-reserved on the very edge its previous write lands.
  assign rsv_ready  = !reset && (!pending_q[rsv_dr] || (ldreg_q && (wb_q.dr == rsv_dr)));
  assign rsv_accept = rsv_valid && rsv_ready;

  // Clear is applied first so a same-edge reservation of that register wins.
  always_comb begin
    pending_d = pending_q;
    if (ldreg_q)    pending_d[wb_q.dr] = 1'b0;
    if (rsv_accept) pending_d[rsv_dr]  = 1'b1;
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      ldreg_q   <= 1'b0;
      wb_q      <= '0;
      pending_q <= '0;
    end else begin
      ldreg_q   <= ldreg_d;
      wb_q      <= wb_d;
      pending_q <= pending_d;
    end
  end

  assign rf_ldreg = ldreg_q;
  assign rf_dr    = wb_q.dr;
  assign rf_in    = wb_q.data;
  assign sr1_busy = pending_q[sr1];
  assign sr2_busy = pending_q[sr2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a small register-file model.
module tb_regfile_wb_arbiter;

  logic        clk_50 = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [8:0]  req_dr;
  logic [47:0] req_data;
  logic [2:0]  req_ready;
  logic        rsv_valid;
  logic [2:0]  rsv_dr;
  logic        rsv_ready;
  logic [2:0]  sr1, sr2;
  logic        sr1_busy, sr2_busy;
  logic [15:0] rf_in;
  logic [2:0]  rf_dr;
  logic        rf_ldreg;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] rf [8] = '{default: 16'h0000};
  logic [2:0]  rr_dr   [3] = '{3'd1, 3'd2, 3'd7};
  logic [15:0] rr_data [3] = '{16'hA001, 16'hB002, 16'hC007};

  always #5 clk_50 = ~clk_50;

  // Register file writes are suppressed while the system is in reset.
  always @(posedge clk_50) begin
    if (!reset && rf_ldreg) rf[rf_dr] <= rf_in;
  end

  regfile_wb_arbiter dut (
    .clk_50    (clk_50),
    .reset     (reset),
    .req_valid (req_valid),
    .req_dr    (req_dr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsv_valid (rsv_valid),
    .rsv_dr    (rsv_dr),
    .rsv_ready (rsv_ready),
    .sr1       (sr1),
    .sr2       (sr2),
    .sr1_busy  (sr1_busy),
    .sr2_busy  (sr2_busy),
    .rf_in     (rf_in),
    .rf_dr     (rf_dr),
    .rf_ldreg  (rf_ldreg)
  );

  task automatic step();
    @(posedge clk_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 3'b111;
    req_dr    = '0;
    req_data  = '0;
    rsv_valid = 1'b0;
    rsv_dr    = 3'd0;
    sr1       = 3'd0;
    sr2       = 3'd0;
    step();
    step();
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_ldreg",     32'(rf_ldreg),  32'h0);
    chk("rst_sr1_busy",  32'(sr1_busy),  32'h0);
    chk("rst_sr2_busy",  32'(sr2_busy),  32'h0);
    chk("rst_rsv_ready", 32'(rsv_ready), 32'h0);
    chk("rst_rf_dr",     32'(rf_dr),     32'h0);
    chk("rst_rf_in",     32'(rf_in),     32'h0);

    // First grant after reset goes to ALU.
    reset = 1'b0;
    #1;
    chk("first_grant", 32'(req_ready), 32'h1);

    req_valid = 3'b001;
    req_dr    = {3'd0, 3'd0, 3'd3};
    req_data  = {16'h0000, 16'h0000, 16'h0011};
    #1;
    chk("alu_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = 3'b000;
    chk("wr_ldreg", 32'(rf_ldreg), 32'h1);
    chk("wr_dr",    32'(rf_dr),    32'h3);
    chk("wr_in",    32'(rf_in),    32'h0011);
    step();
    chk("wr_rf3",      32'(rf[3]),    32'h0011);
    chk("wr_ldreg_lo", 32'(rf_ldreg), 32'h0);

    // Fresh pointer, then all three requesters continuously valid.
    reset = 1'b1;
    step();
    reset     = 1'b0;
    req_valid = 3'b111;
    req_dr    = {rr_dr[2], rr_dr[1], rr_dr[0]};
    req_data  = {rr_data[2], rr_data[1], rr_data[0]};
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_grant", 32'(req_ready), 32'(3'b001 << (k % 3)));
      step();
      chk("rr_ldreg", 32'(rf_ldreg), 32'h1);
      chk("rr_dr",    32'(rf_dr),    32'(rr_dr[k % 3]));
      chk("rr_in",    32'(rf_in),    32'(rr_data[k % 3]));
    end
    req_valid = 3'b000;

    // Reserve R5 and probe hazards.
    rsv_valid = 1'b1;
    rsv_dr    = 3'd5;
    sr1       = 3'd5;
    #1;
    chk("rsv5_ready",  32'(rsv_ready), 32'h1);
    chk("sr1_idle",    32'(sr1_busy),  32'h0);
    step();
    chk("sr1_busy",    32'(sr1_busy),  32'h1);
    chk("rsv5_dup",    32'(rsv_ready), 32'h0);
    rsv_valid = 1'b0;

    req_valid = 3'b010;
    req_dr    = {3'd0, 3'd5, 3'd0};
    req_data  = {16'h0000, 16'h5555, 16'h0000};
    #1;
    chk("mem_grant", 32'(req_ready), 32'h2);
    step();
    req_valid = 3'b000;
    chk("mem_ldreg",     32'(rf_ldreg), 32'h1);
    chk("mem_dr",        32'(rf_dr),    32'h5);
    chk("busy_wr_cycle", 32'(sr1_busy), 32'h1);
    step();
    chk("busy_dropped",  32'(sr1_busy), 32'h0);
    chk("rf5_first",     32'(rf[5]),    32'h5555);

    rsv_valid = 1'b1;
    rsv_dr    = 3'd5;
    #1;
    chk("rsv5_again", 32'(rsv_ready), 32'h1);
    step();
    rsv_valid = 1'b0;
    chk("sr1_busy_again", 32'(sr1_busy), 32'h1);

    // Re-reserve R5 in the cycle its write is in flight: set wins.
    req_valid = 3'b010;
    req_data  = {16'h0000, 16'h6666, 16'h0000};
    #1;
    chk("mem_grant2", 32'(req_ready), 32'h2);
    step();
    req_valid = 3'b000;
    rsv_valid = 1'b1;
    rsv_dr    = 3'd5;
    #1;
    chk("rsv_in_wr_cycle", 32'(rsv_ready), 32'h1);
    step();
    rsv_valid = 1'b0;
    chk("set_wins",   32'(sr1_busy), 32'h1);
    chk("rf5_second", 32'(rf[5]),    32'h6666);

    // Reset while a LINK write is in flight.
    sr2       = 3'd7;
    rsv_valid = 1'b1;
    rsv_dr    = 3'd7;
    #1;
    chk("rsv7_ready", 32'(rsv_ready), 32'h1);
    step();
    rsv_valid = 1'b0;
    chk("sr2_busy", 32'(sr2_busy), 32'h1);
    req_valid = 3'b100;
    req_dr    = {3'd7, 3'd0, 3'd0};
    req_data  = {16'h3000, 16'h0000, 16'h0000};
    #1;
    chk("link_grant", 32'(req_ready), 32'h4);
    step();
    req_valid = 3'b000;
    reset     = 1'b1;
    chk("link_ldreg", 32'(rf_ldreg), 32'h1);
    chk("link_dr",    32'(rf_dr),    32'h7);
    step();
    chk("midrst_ldreg", 32'(rf_ldreg),  32'h0);
    chk("midrst_r7",    32'(rf[7]),     32'hC007);
    chk("midrst_sr2",   32'(sr2_busy),  32'h0);
    chk("midrst_sr1",   32'(sr1_busy),  32'h0);
    chk("midrst_ready", 32'(req_ready), 32'h0);
    reset = 1'b0;
    step();
    chk("post_rst_r7", 32'(rf[7]), 32'hC007);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
